// File: rtl/prng_xoshiro256_jumper_if.sv
// rtl/prng_xoshiro256_jumper_if.sv - user and generator signal bundle for the xoshiro256 jumper
// Purpose: groups the request handshake, the user passthrough controls and the
//          generator-facing state/seed signals of prng_xoshiro256_jumper.
// Ports (signal members):
//   i_req, i_long, o_ready, o_done          jump request handshake
//   i_cg, i_seedValid, i_seedS0..3          user advance/seed, passed through when idle
//   i_s0..3                                 current generator state
//   o_prngCg, o_seedValid, o_seedS0..3      drive the generator's cg and seed inputs
// Modports: slave = the jumper, master = user/generator side.
interface prng_xoshiro256_jumper_if;
   logic        i_req;
   logic        i_long;
   logic        o_ready;
   logic        o_done;
   logic        i_cg;
   logic        i_seedValid;
   logic [63:0] i_seedS0;
   logic [63:0] i_seedS1;
   logic [63:0] i_seedS2;
   logic [63:0] i_seedS3;
   logic [63:0] i_s0;
   logic [63:0] i_s1;
   logic [63:0] i_s2;
   logic [63:0] i_s3;
   logic        o_prngCg;
   logic        o_seedValid;
   logic [63:0] o_seedS0;
   logic [63:0] o_seedS1;
   logic [63:0] o_seedS2;
   logic [63:0] o_seedS3;

   modport slave (
      input  i_req, i_long, i_cg, i_seedValid,
      input  i_seedS0, i_seedS1, i_seedS2, i_seedS3,
      input  i_s0, i_s1, i_s2, i_s3,
      output o_ready, o_done, o_prngCg, o_seedValid,
      output o_seedS0, o_seedS1, o_seedS2, o_seedS3
   );

   modport master (
      output i_req, i_long, i_cg, i_seedValid,
      output i_seedS0, i_seedS1, i_seedS2, i_seedS3,
      output i_s0, i_s1, i_s2, i_s3,
      input  o_ready, o_done, o_prngCg, o_seedValid,
      input  o_seedS0, o_seedS1, o_seedS2, o_seedS3
   );
endinterface

// File: rtl/prng_xoshiro256_jumper.sv
// rtl/prng_xoshiro256_jumper.sv - jump()/long_jump() engine for an external xoshiro256 generator
// Purpose: on request, steps the attached generator 256 times while XOR-accumulating
//          its state under the selected polynomial, then reseeds it with the result.
// Ports:
//   i_clk   clock, all state on the rising edge
//   i_rstn  synchronous active-low reset
//   bus     prng_xoshiro256_jumper_if.slave (handshake, passthrough, generator link)
module prng_xoshiro256_jumper #(
   parameter logic [255:0] JUMP_POLY      = 256'h39abdc4529b1661c_a9582618e03fc9aa_d5a61266f0c9392c_180ec6d33cfd0aba,
   parameter logic [255:0] LONG_JUMP_POLY = 256'h39109bb02acbe635_77710069854ee241_c5004e441c522fb3_76e15d3efefdcbbf
) (
   input  logic                          i_clk,
   input  logic                          i_rstn,
   prng_xoshiro256_jumper_if.slave       bus
);

   typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;

   state_t         state;
   logic [7:0]     k;
   logic [255:0]   acc;
   logic [255:0]   poly;
   logic           done;
   logic           ready;
   logic [255:0]   cur;

   assign cur = {bus.i_s3, bus.i_s2, bus.i_s1, bus.i_s0};

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state <= IDLE;
         k     <= 8'd0;
         acc   <= '0;
         poly  <= '0;
         done  <= 1'b0;
         ready <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_req) begin
                  poly  <= bus.i_long ? LONG_JUMP_POLY : JUMP_POLY;
                  acc   <= '0;
                  k     <= 8'd0;
                  ready <= 1'b0;
                  state <= RUN;
               end
            end
            RUN: begin
               // Generator is advanced every RUN cycle, so cur is step k of the walk.
               if (poly[k]) begin
                  acc <= acc ^ cur;
               end
               k <= k + 8'd1;
               if (k == 8'd255) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               // Generator takes the seed at the end of this cycle; done marks
               // the first cycle in which it holds the jumped state.
               done  <= 1'b1;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.o_ready = ready;
   assign bus.o_done  = done;

   always_comb begin
      bus.o_prngCg    = 1'b1;
      bus.o_seedValid = 1'b0;
      bus.o_seedS0    = acc[63:0];
      bus.o_seedS1    = acc[127:64];
      bus.o_seedS2    = acc[191:128];
      bus.o_seedS3    = acc[255:192];
      case (state)
         IDLE: begin
            bus.o_prngCg    = bus.i_cg;
            bus.o_seedValid = bus.i_seedValid;
            bus.o_seedS0    = bus.i_seedS0;
            bus.o_seedS1    = bus.i_seedS1;
            bus.o_seedS2    = bus.i_seedS2;
            bus.o_seedS3    = bus.i_seedS3;
         end
         LOAD: begin
            bus.o_seedValid = 1'b1;
         end
         default: begin
            bus.o_seedValid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_prng_xoshiro256_jumper.sv
// tb/tb_prng_xoshiro256_jumper.sv - self-checking bench for prng_xoshiro256_jumper
// Purpose: drives the jumper against a behavioural xoshiro256 generator and compares
//          jumped states with a software jump()/long_jump() model.
// Ports: none (top-level bench).
module tb_prng_xoshiro256_jumper;

   localparam logic [255:0] JP  = 256'h39abdc4529b1661c_a9582618e03fc9aa_d5a61266f0c9392c_180ec6d33cfd0aba;
   localparam logic [255:0] LJP = 256'h39109bb02acbe635_77710069854ee241_c5004e441c522fb3_76e15d3efefdcbbf;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   prng_xoshiro256_jumper_if bus ();

   prng_xoshiro256_jumper dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus)
   );

   function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
      return (x << r) | (x >> (64 - r));
   endfunction

   function automatic logic [255:0] xo_next(input logic [255:0] s);
      logic [63:0] s0, s1, s2, s3, t;
      s0 = s[63:0]; s1 = s[127:64]; s2 = s[191:128]; s3 = s[255:192];
      t  = s1 << 17;
      s2 ^= s0; s3 ^= s1; s1 ^= s2; s0 ^= s3; s2 ^= t;
      s3 = rotl(s3, 45);
      return {s3, s2, s1, s0};
   endfunction

   function automatic logic [63:0] xo_result(input logic [255:0] s);
      return rotl(s[127:64] * 64'd5, 7) * 64'd9;
   endfunction

   // Reference software jump: walk polynomial bits LSB-first, word 0 first.
   function automatic logic [255:0] sw_jump(input logic [255:0] s_in, input logic [255:0] p);
      logic [255:0] s, a;
      s = s_in; a = '0;
      for (int i = 0; i < 256; i++) begin
         if (p[i]) a ^= s;
         s = xo_next(s);
      end
      return a;
   endfunction

   // Generator A is driven by the jumper; generator B directly by the user inputs.
   logic [255:0] ga = '0;
   logic [255:0] gb = '0;

   always @(posedge clk) begin
      if (bus.o_seedValid) ga <= {bus.o_seedS3, bus.o_seedS2, bus.o_seedS1, bus.o_seedS0};
      else if (bus.o_prngCg) ga <= xo_next(ga);
      if (bus.i_seedValid) gb <= {bus.i_seedS3, bus.i_seedS2, bus.i_seedS1, bus.i_seedS0};
      else if (bus.i_cg) gb <= xo_next(gb);
   end

   assign bus.i_s0 = ga[63:0];
   assign bus.i_s1 = ga[127:64];
   assign bus.i_s2 = ga[191:128];
   assign bus.i_s3 = ga[255:192];

   task automatic idle_inputs();
      bus.i_req = 1'b0; bus.i_long = 1'b0; bus.i_cg = 1'b0; bus.i_seedValid = 1'b0;
      bus.i_seedS0 = '0; bus.i_seedS1 = '0; bus.i_seedS2 = '0; bus.i_seedS3 = '0;
   endtask

   task automatic load_seed(input logic [255:0] seed);
      @(posedge clk); #1;
      bus.i_seedValid = 1'b1;
      {bus.i_seedS3, bus.i_seedS2, bus.i_seedS1, bus.i_seedS0} = seed;
      @(posedge clk); #1;
      idle_inputs();
   endtask

   // Drives one request at cycle T (call just after a rising edge) and records
   // what happens over cycles T+1..T+ncyc.
   task automatic run_jump(input logic lng, input logic with_seed, input logic [255:0] seed,
                           input bit hold_req, input int pulse_at, input int rst_at, input int ncyc,
                           output int done_at, output int done_cnt, output int sv_cnt, output int sv_at,
                           output int ready_low_bad, output logic ready_t, output logic ready102,
                           output logic ready258, output logic ready259,
                           output logic [255:0] st_done, output logic [63:0] res_done);
      done_at = -1; done_cnt = 0; sv_cnt = 0; sv_at = -1; ready_low_bad = 0;
      ready102 = 1'b0; ready258 = 1'b0; ready259 = 1'b0; st_done = '0; res_done = '0;
      bus.i_req = 1'b1; bus.i_long = lng; bus.i_cg = 1'b0; bus.i_seedValid = with_seed;
      {bus.i_seedS3, bus.i_seedS2, bus.i_seedS1, bus.i_seedS0} = seed;
      @(negedge clk);
      ready_t = bus.o_ready;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk); #1;
         bus.i_req       = hold_req;
         bus.i_long      = ~lng;
         bus.i_cg        = 1'b0;
         bus.i_seedValid = (c == pulse_at);
         bus.i_seedS0 = {$urandom, $urandom}; bus.i_seedS1 = {$urandom, $urandom};
         bus.i_seedS2 = {$urandom, $urandom}; bus.i_seedS3 = {$urandom, $urandom};
         rstn = (c != rst_at);
         @(negedge clk);
         if (bus.o_done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = c; st_done = ga; res_done = xo_result(ga);
            end
         end
         if (bus.o_seedValid === 1'b1) begin sv_cnt++; sv_at = c; end
         if (c <= 257 && bus.o_ready !== 1'b0) ready_low_bad++;
         if (c == 102) ready102 = bus.o_ready;
         if (c == 258) ready258 = bus.o_ready;
         if (c == 259) ready259 = bus.o_ready;
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      rstn = 1'b0; bus.i_req = 1'b1;
      repeat (3) @(posedge clk);
      #1; rstn = 1'b1; bus.i_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
      n_checks++;
      if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
      @(posedge clk); #1;
      bus.i_cg = 1'b1; bus.i_seedValid = 1'b1;
      bus.i_seedS0 = 64'h1111; bus.i_seedS1 = 64'h2222; bus.i_seedS2 = 64'h3333; bus.i_seedS3 = 64'h4444;
      @(negedge clk);
      n_checks++;
      if (bus.o_prngCg !== 1'b1) begin n_fail++; $display("FAIL pass_cg1: got %b want 1", bus.o_prngCg); end
      n_checks++;
      if (bus.o_seedValid !== 1'b1) begin n_fail++; $display("FAIL pass_sv1: got %b want 1", bus.o_seedValid); end
      n_checks++;
      if (bus.o_seedS0 !== 64'h1111) begin n_fail++; $display("FAIL pass_s0: got %h want 1111", bus.o_seedS0); end
      n_checks++;
      if (bus.o_seedS3 !== 64'h4444) begin n_fail++; $display("FAIL pass_s3: got %h want 4444", bus.o_seedS3); end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      n_checks++;
      if (bus.o_prngCg !== 1'b0) begin n_fail++; $display("FAIL pass_cg0: got %b want 0", bus.o_prngCg); end
      n_checks++;
      if (bus.o_seedValid !== 1'b0) begin n_fail++; $display("FAIL pass_sv0: got %b want 0", bus.o_seedValid); end
   endtask

   task automatic test_jump(input logic lng, input string nm);
      logic [255:0] seed, st; logic [63:0] res;
      int da, dc, sc, sa, rlb; logic rt, r102, r258, r259;
      seed = {64'd4, 64'd3, 64'd2, 64'd1};
      load_seed(seed);
      run_jump(lng, 1'b0, '0, 1'b0, 0, 0, 260, da, dc, sc, sa, rlb, rt, r102, r258, r259, st, res);
      n_checks++;
      if (rt !== 1'b1) begin n_fail++; $display("FAIL %s_ready_T: got %b want 1", nm, rt); end
      n_checks++;
      if (da != 258) begin n_fail++; $display("FAIL %s_latency: got %0d want 258", nm, da); end
      n_checks++;
      if (dc != 1) begin n_fail++; $display("FAIL %s_done_count: got %0d want 1", nm, dc); end
      n_checks++;
      if (sc != 1 || sa != 257) begin n_fail++; $display("FAIL %s_seedvalid: got count %0d at %0d want 1 at 257", nm, sc, sa); end
      n_checks++;
      if (rlb != 0) begin n_fail++; $display("FAIL %s_ready_low: got %0d high cycles want 0", nm, rlb); end
      n_checks++;
      if (r258 !== 1'b1) begin n_fail++; $display("FAIL %s_ready_258: got %b want 1", nm, r258); end
      n_checks++;
      if (st !== sw_jump(seed, lng ? LJP : JP)) begin
         n_fail++; $display("FAIL %s_state: got %h want %h", nm, st, sw_jump(seed, lng ? LJP : JP));
      end
      n_checks++;
      if (res !== xo_result(sw_jump(seed, lng ? LJP : JP))) begin
         n_fail++; $display("FAIL %s_result: got %h want %h", nm, res, xo_result(sw_jump(seed, lng ? LJP : JP)));
      end
   endtask

   task automatic test_seed_with_req();
      logic [255:0] seed, st; logic [63:0] res;
      int da, dc, sc, sa, rlb; logic rt, r102, r258, r259;
      seed = {64'd8, 64'd7, 64'd6, 64'd5};
      @(posedge clk); #1;
      run_jump(1'b0, 1'b1, seed, 1'b0, 0, 0, 260, da, dc, sc, sa, rlb, rt, r102, r258, r259, st, res);
      n_checks++;
      if (da != 258) begin n_fail++; $display("FAIL seedreq_latency: got %0d want 258", da); end
      n_checks++;
      if (st !== sw_jump(seed, JP)) begin n_fail++; $display("FAIL seedreq_state: got %h want %h", st, sw_jump(seed, JP)); end
   endtask

   task automatic test_back_to_back();
      logic [255:0] seed, st, exp1, exp2; logic [63:0] res;
      int da, dc, sc, sa, rlb; logic rt, r102, r258, r259; bit seen;
      seed = {64'd4, 64'd3, 64'd2, 64'd1};
      exp1 = sw_jump(seed, JP);
      exp2 = sw_jump(exp1, LJP);
      load_seed(seed);
      run_jump(1'b0, 1'b0, '0, 1'b1, 100, 0, 262, da, dc, sc, sa, rlb, rt, r102, r258, r259, st, res);
      n_checks++;
      if (dc != 1 || da != 258) begin n_fail++; $display("FAIL b2b_done: got %0d pulses first at %0d want 1 at 258", dc, da); end
      n_checks++;
      if (sc != 1 || sa != 257) begin n_fail++; $display("FAIL b2b_seedvalid: got count %0d at %0d want 1 at 257", sc, sa); end
      n_checks++;
      if (rlb != 0) begin n_fail++; $display("FAIL b2b_ready_low: got %0d high cycles want 0", rlb); end
      n_checks++;
      if (r258 !== 1'b1 || r259 !== 1'b0) begin n_fail++; $display("FAIL b2b_reaccept: got ready %b/%b want 1/0", r258, r259); end
      n_checks++;
      if (st !== exp1) begin n_fail++; $display("FAIL b2b_state1: got %h want %h", st, exp1); end
      // Second jump was accepted at T+258 with i_long high; let it finish.
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         @(negedge clk);
         if (bus.o_done === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL b2b_second_done: got none want pulse"); end
      n_checks++;
      if (ga !== exp2) begin n_fail++; $display("FAIL b2b_state2: got %h want %h", ga, exp2); end
   endtask

   task automatic test_reset_abort();
      logic [255:0] seed, st; logic [63:0] res;
      int da, dc, sc, sa, rlb; logic rt, r102, r258, r259;
      seed = {64'd4, 64'd3, 64'd2, 64'd1};
      load_seed(seed);
      run_jump(1'b0, 1'b0, '0, 1'b0, 102, 100, 262, da, dc, sc, sa, rlb, rt, r102, r258, r259, st, res);
      n_checks++;
      if (dc != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", dc); end
      n_checks++;
      if (sc != 1 || sa != 102) begin n_fail++; $display("FAIL abort_seedvalid: got count %0d at %0d want 1 at 102", sc, sa); end
      n_checks++;
      if (r102 !== 1'b1) begin n_fail++; $display("FAIL abort_ready_102: got %b want 1", r102); end
   endtask

   task automatic test_passthrough_equiv();
      load_seed({64'hdead, 64'hbeef, 64'hcafe, 64'hf00d});
      @(negedge clk);
      n_checks++;
      if (ga !== gb) begin n_fail++; $display("FAIL equiv_sync: got %h want %h", ga, gb); end
      for (int c = 0; c < 1000; c++) begin
         @(posedge clk); #1;
         bus.i_cg        = $urandom_range(0, 1);
         bus.i_seedValid = ($urandom_range(0, 7) == 0);
         bus.i_seedS0 = {$urandom, $urandom}; bus.i_seedS1 = {$urandom, $urandom};
         bus.i_seedS2 = {$urandom, $urandom}; bus.i_seedS3 = {$urandom, $urandom};
         @(negedge clk);
         n_checks++;
         if (ga !== gb) begin n_fail++; $display("FAIL equiv_cycle%0d: got %h want %h", c, ga, gb); end
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_jump(1'b0, "jump");
      test_jump(1'b1, "long_jump");
      test_seed_with_req();
      test_back_to_back();
      test_reset_abort();
      test_passthrough_equiv();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
